// File: rtl/div5b_pkg.sv
// Shared widths and FSM encoding for the div5b family of arithmetic blocks.
package div5b_pkg;

  localparam int DW = 10;
  localparam int VW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div5b_seq_if.sv
// Request/result bundle for the sequential divider.
interface div5b_seq_if #(
  parameter int DW = div5b_pkg::DW,
  parameter int VW = div5b_pkg::VW
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dz
  );
endinterface

// File: rtl/div5b_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, select.
module div5b_step #(
  parameter int VW = div5b_pkg::VW
) (
  input  logic [VW:0]   rem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_out,
  output logic          q_bit
);
  logic [VW:0]   trial;
  logic [VW+1:0] diff;

  assign trial = {rem_in[VW-1:0], bit_in};
  assign diff  = {1'b0, trial} - {2'b00, divisor};

  // A set rem_in MSB would mean the true trial exceeds any divisor; never
  // reached while rem_in < divisor, but it keeps the select well defined.
  assign q_bit   = ~diff[VW+1] | rem_in[VW];
  assign rem_out = q_bit ? diff[VW:0] : trial;
endmodule

// File: rtl/div5b_seq.sv
// Sequential unsigned divider: one quotient bit per clock, restoring, MSB-first.
module div5b_seq #(
  parameter int DW = div5b_pkg::DW,
  parameter int VW = div5b_pkg::VW
) (
  input  logic        clk,
  input  logic        rst_n,
  div5b_seq_if.slave  bus
);
  import div5b_pkg::*;

  localparam int CW = $clog2(DW + 1);

  div_state_t    state, state_nx;
  logic          accept;
  logic          last;

  // Working registers: dvd_w shifts dividend bits out and quotient bits in.
  logic [DW-1:0] dvd_w;
  logic [VW-1:0] dvs_w;
  logic [VW:0]   rem_w;
  logic [CW-1:0] cnt;

  logic [DW-1:0] quo_q;
  logic [VW-1:0] rem_q;
  logic          dz_q;

  logic [VW:0]   rem_nx;
  logic          q_bit;

  div5b_step #(.VW(VW)) u_step (
    .rem_in  (rem_w),
    .bit_in  (dvd_w[DW-1]),
    .divisor (dvs_w),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  assign last = (cnt == CW'(DW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = (bus.divisor == '0) ? DONE : RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in RUN, publish on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_w <= '0;
      dvs_w <= '0;
      rem_w <= '0;
      cnt   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dz_q  <= 1'b0;
    end else if (accept) begin
      dvd_w <= bus.dividend;
      dvs_w <= bus.divisor;
      rem_w <= '0;
      cnt   <= '0;
      if (bus.divisor == '0) begin
        quo_q <= '1;
        rem_q <= '0;
        dz_q  <= 1'b1;
      end else begin
        dz_q  <= 1'b0;
      end
    end else if (state == RUN) begin
      dvd_w <= {dvd_w[DW-2:0], q_bit};
      rem_w <= rem_nx;
      cnt   <= cnt + CW'(1);
      if (last) begin
        quo_q <= {dvd_w[DW-2:0], q_bit};
        rem_q <= rem_nx[VW-1:0];
      end
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.dz        = dz_q;
endmodule

// File: doc/div5b_seq.md
DIV5B_SEQ -- requirements
Module: div5b_seq

Interface
REQ-001 SHALL have parameters: DW, default 10, dividend/quotient width; VW, default 5, divisor/remainder width.
REQ-002 SHALL have ports: clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: start  input  1  request a division; sampled when not busy.
REQ-005 SHALL have ports: dividend  input  DW  unsigned numerator; captured with start.
REQ-006 SHALL have ports: divisor  input  VW  unsigned denominator; captured with start.
REQ-007 SHALL have ports: busy  output  1  division in progress.
REQ-008 SHALL have ports: done  output  1  one-cycle pulse: results valid.
REQ-009 SHALL have ports: quotient  output  DW  unsigned result.
REQ-010 SHALL have ports: remainder  output  VW  unsigned result.
REQ-011 SHALL have ports: dz  output  1  last division had divisor 0.

Function
REQ-012 SHALL be an FSM with exactly three states: IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE or DONE with start=1, latch dividend and divisor on the clock edge and clear the partial remainder and the iteration counter.
REQ-014 SHALL, on that edge, enter RUN when the divisor is nonzero, or enter DONE directly when the divisor is zero.
REQ-015 SHALL perform restoring division MSB-first in RUN, one quotient bit per clock, for exactly DW iterations.
REQ-016 SHALL form each iteration's trial value as {partial_remainder, next dividend bit}, VW+1 bits wide.
REQ-017 SHALL subtract the zero-extended divisor from the trial value: if non-negative, keep the difference and set the quotient bit to 1; otherwise keep the trial value and set the bit to 0.
REQ-018 SHALL hold the partial remainder in VW+1 bits internally and present the low VW bits on remainder; the final remainder is always less than the divisor.
REQ-019 SHALL take the DW-th iteration edge from RUN to DONE, so done is high in the cycle after the DW-th iteration edge (DW+1 edges after the start-sampling edge).
REQ-020 SHALL assert busy exactly while in RUN.
REQ-021 SHALL assert done exactly while in DONE; DONE lasts one cycle and then returns to IDLE unless start=1.
REQ-022 SHALL hold quotient, remainder and dz stable from DONE until the edge that accepts the next start.
REQ-023 SHALL, on a zero divisor, produce quotient all-ones (10'h3FF), remainder 0 and dz=1, with done in the cycle after the start edge.
REQ-024 SHALL clear dz on the next accepted start with a nonzero divisor.
REQ-025 SHALL ignore start while busy; the operands in flight SHALL be unaffected.
REQ-026 SHALL accept start in the DONE cycle as back-to-back operation: no IDLE cycle is inserted, and the new operands are latched.
REQ-027 SHALL have no combinational path from inputs to outputs; all outputs are registered.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-division, immediately set state IDLE, busy 0, done 0, quotient 0, remainder 0, dz 0, counter 0, and abandon any in-flight division.
REQ-029 SHALL start no operation on the first edge after rst_n deasserts unless start=1 is sampled on that edge.

Structure
REQ-030 SHALL take DW, VW and the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) from shared package div5b_pkg, which the other arithmetic blocks also use.
REQ-031 SHALL place one restoring step (trial subtract, select, quotient bit) in combinational sub-module div5b_step, instantiated once and reused each cycle.
REQ-032 SHALL size the iteration counter as ceil(log2(DW+1)) bits.

Verification
REQ-033 SHALL check: 1000 / 31 -> quotient 32, remainder 8, dz 0, done in the 11th cycle after start.
REQ-034 SHALL check: 1023 / 1 -> quotient 1023, remainder 0; and 7 / 9 -> quotient 0, remainder 7.
REQ-035 SHALL check: 500 / 0 -> quotient 10'h3FF, remainder 0, dz 1, done one cycle after start, busy never high.
REQ-036 SHALL check: start 100 / 7, then pulse start with 50 / 3 mid-RUN -> result 14 r 2 and the second request ignored; then start 50 / 3 in the DONE cycle -> 16 r 2 with no idle gap.
REQ-037 SHALL check: rst_n low at iteration 5 of 900 / 13 -> all outputs 0 immediately; then new start 900 / 13 -> 69 r 3.
REQ-038 SHALL check: random sweep of all 1024 x 32 operand pairs against a golden model (x/y, x%y) -> zero mismatches.
